// File: rtl/booth_seq_mult_ctrl.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle through a single
// WIDTH+1-bit partial-product path, accumulated into a 2*WIDTH-bit product.
module booth_seq_mult_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 abort,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int N     = WIDTH / 2;
   localparam int PW    = 2 * WIDTH;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic zero;
      logic two;
      logic neg;
   } booth_t;

   state_e                   state_q, state_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [PW-1:0]            acc_q, acc_d;
   logic [PW-1:0]            prod_q, prod_d;
   logic signed [WIDTH-1:0]  a_q;
   logic [WIDTH:0]           bwin_q;
   logic                     load;
   booth_t                   dig;
   logic signed [WIDTH:0]    pp;

   function automatic booth_t booth_decode(input logic [2:0] w);
      booth_t d;
      d = '0;
      case (w)
         3'b000, 3'b111: d.zero = 1'b1;
         3'b001, 3'b010: d.zero = 1'b0;
         3'b011:         d.two  = 1'b1;
         3'b100: begin
            d.two = 1'b1;
            d.neg = 1'b1;
         end
         default:        d.neg  = 1'b1;
      endcase
      return d;
   endfunction

   // Negative digits return the one's complement; the +1 is added in accumulate().
   function automatic logic signed [WIDTH:0] partial_product(
      input logic signed [WIDTH-1:0] m,
      input booth_t                  d
   );
      logic signed [WIDTH:0] mag;
      mag = d.two ? {m, 1'b0} : {m[WIDTH-1], m};
      if (d.zero) begin
         mag = '0;
      end
      return d.neg ? ~mag : mag;
   endfunction

   function automatic logic [PW-1:0] accumulate(
      input logic [PW-1:0]         acc,
      input logic signed [WIDTH:0] p,
      input logic                  neg,
      input logic [IDX_W-1:0]      idx
   );
      logic [PW-1:0]    ext;
      logic [IDX_W:0]   sh;
      ext = {{(PW-WIDTH-1){p[WIDTH]}}, p};
      sh  = {idx, 1'b0};
      return acc + (ext << sh) + (PW'(neg) << sh);
   endfunction

   assign dig = booth_decode(bwin_q[2:0]);
   assign pp  = partial_product(a_q, dig);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else begin
               acc_d = accumulate(acc_q, pp, dig.neg, idx_q);
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  prod_d  = acc_d;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

   // Operand registers carry no reset; the window shifts one Booth digit per RUN cycle.
   always_ff @(posedge clk) begin
      if (load) begin
         a_q    <= $signed(a);
         bwin_q <= {b, 1'b0};
      end else if (state_q == S_RUN) begin
         bwin_q <= bwin_q >> 2;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign busy    = (state_q == S_RUN);
   assign done    = (state_q == S_DONE);
   assign product = prod_q;

endmodule
